// File: rtl/fp_result_queue.sv
// fp_result_queue: FIFO of packed FP results with RISC-V sticky exception flag accumulation.
package addpkg;
  typedef logic [2:0] o_err_t;
  localparam o_err_t ERR_NONE      = 3'd0;
  localparam o_err_t ERR_INVALID   = 3'd1;
  localparam o_err_t ERR_DIVZERO   = 3'd2;
  localparam o_err_t ERR_OVERFLOW  = 3'd3;
  localparam o_err_t ERR_UNDERFLOW = 3'd4;
  localparam o_err_t ERR_INEXACT   = 3'd5;
endpackage

module fp_result_queue
  import addpkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              fp_in,
  input  o_err_t                   err_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              fp_q,
  output o_err_t                   err_q,
  output logic [$clog2(DEPTH):0]   count,
  output logic [4:0]               fflags,
  input  logic                     fflags_clr,
  input  logic                     fflags_we,
  input  logic [4:0]               fflags_wdata
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [31:0] fp_mem [DEPTH];
  o_err_t err_mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic push, pop;
  logic [4:0] new_flag;
  always_comb begin
    in_ready = (count != FULL) && !rst;
    out_valid = count != '0;
    push = in_valid && in_ready;
    pop = out_valid && out_ready;
    fp_q = fp_mem[rd_ptr];
    err_q = err_mem[rd_ptr];
    new_flag = push ? {err_in == ERR_INVALID, err_in == ERR_DIVZERO, err_in == ERR_OVERFLOW,
                       err_in == ERR_UNDERFLOW, err_in == ERR_INEXACT} : 5'b0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      fflags <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fp_mem[i] <= '0;
        err_mem[i] <= ERR_NONE;
      end
    end else begin
      if (push) begin
        fp_mem[wr_ptr] <= fp_in;
        err_mem[wr_ptr] <= err_in;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= (push && !pop) ? count + 1'b1 : (pop && !push) ? count - 1'b1 : count;
      // A flag raised this cycle survives a simultaneous clear or fcsr write.
      fflags <= (fflags_we ? fflags_wdata : fflags_clr ? 5'b0 : fflags) | new_flag;
    end
  end
endmodule

// File: tb/tb_fp_result_queue.sv
// tb_fp_result_queue: directed table-driven checks of fp_result_queue plus streaming and reset sequences.
module tb_fp_result_queue;
  import addpkg::*;
  logic clk = 0;
  logic rst, in_valid, in_ready, out_valid, out_ready, fflags_clr, fflags_we;
  logic [31:0] fp_in, fp_q;
  o_err_t err_in, err_q;
  logic [2:0] count;
  logic [4:0] fflags, fflags_wdata;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  fp_result_queue #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .fp_in(fp_in),
    .err_in(err_in), .out_valid(out_valid), .out_ready(out_ready), .fp_q(fp_q),
    .err_q(err_q), .count(count), .fflags(fflags), .fflags_clr(fflags_clr),
    .fflags_we(fflags_we), .fflags_wdata(fflags_wdata)
  );
  typedef struct packed {
    logic iv; logic [31:0] fp; logic [2:0] err; logic ordy; logic clr; logic we; logic [4:0] wd;
    logic ov; logic [31:0] efp; logic [2:0] eerr; logic [2:0] ecnt; logic [4:0] eff; logic eir;
  } vec_t;
  vec_t tbl[$];
  function automatic vec_t mk(logic iv, logic [31:0] fp, logic [2:0] err, logic ordy, logic clr,
                              logic we, logic [4:0] wd, logic ov, logic [31:0] efp,
                              logic [2:0] eerr, logic [2:0] ecnt, logic [4:0] eff, logic eir);
    return '{iv, fp, err, ordy, clr, we, wd, ov, efp, eerr, ecnt, eff, eir};
  endfunction
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h", n, a, e);
    end
  endtask
  task automatic drive(input logic iv, input logic [31:0] fp, input logic [2:0] err, input logic ordy,
                       input logic clr, input logic we, input logic [4:0] wd);
    in_valid = iv; fp_in = fp; err_in = err; out_ready = ordy;
    fflags_clr = clr; fflags_we = we; fflags_wdata = wd;
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1;
    drive(0, 0, 0, 0, 0, 0, 0);
    tick; tick;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_fflags", fflags, 0);
    chk("rst_fp_q", fp_q, 0);
    chk("rst_err_q", err_q, ERR_NONE);
    rst = 0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    // single push, then drain
    tbl.push_back(mk(1, 32'h3F800000, ERR_NONE, 0, 0, 0, 0, 1, 32'h3F800000, ERR_NONE, 1, 0, 1));
    tbl.push_back(mk(0, 0, ERR_NONE, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    // fill to full, rejected 5th, no bypass on full push+pop, drain in order
    tbl.push_back(mk(1, 32'h11111111, ERR_NONE, 0, 0, 0, 0, 1, 32'h11111111, ERR_NONE, 1, 0, 1));
    tbl.push_back(mk(1, 32'h22222222, ERR_NONE, 0, 0, 0, 0, 1, 32'h11111111, ERR_NONE, 2, 0, 1));
    tbl.push_back(mk(1, 32'h33333333, ERR_NONE, 0, 0, 0, 0, 1, 32'h11111111, ERR_NONE, 3, 0, 1));
    tbl.push_back(mk(1, 32'h44444444, ERR_NONE, 0, 0, 0, 0, 1, 32'h11111111, ERR_NONE, 4, 0, 0));
    tbl.push_back(mk(1, 32'h55555555, ERR_NONE, 0, 0, 0, 0, 1, 32'h11111111, ERR_NONE, 4, 0, 0));
    tbl.push_back(mk(1, 32'h55555555, ERR_NONE, 1, 0, 0, 0, 1, 32'h22222222, ERR_NONE, 3, 0, 1));
    tbl.push_back(mk(0, 0, ERR_NONE, 1, 0, 0, 0, 1, 32'h33333333, ERR_NONE, 2, 0, 1));
    tbl.push_back(mk(0, 0, ERR_NONE, 1, 0, 0, 0, 1, 32'h44444444, ERR_NONE, 1, 0, 1));
    tbl.push_back(mk(0, 0, ERR_NONE, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    // flag accumulation; pops leave flags alone
    tbl.push_back(mk(1, 32'h7F800000, ERR_OVERFLOW, 0, 0, 0, 0, 1, 32'h7F800000, ERR_OVERFLOW, 1, 5'b00100, 1));
    tbl.push_back(mk(1, 32'h7FFFFFFF, ERR_INVALID, 0, 0, 0, 0, 1, 32'h7F800000, ERR_OVERFLOW, 2, 5'b10100, 1));
    tbl.push_back(mk(0, 0, ERR_NONE, 1, 0, 0, 0, 1, 32'h7FFFFFFF, ERR_INVALID, 1, 5'b10100, 1));
    tbl.push_back(mk(0, 0, ERR_NONE, 1, 0, 0, 0, 0, 0, 0, 0, 5'b10100, 1));
    // clear/write vs new flag
    tbl.push_back(mk(1, 32'h00000001, ERR_UNDERFLOW, 0, 1, 0, 0, 1, 32'h00000001, ERR_UNDERFLOW, 1, 5'b00010, 1));
    tbl.push_back(mk(0, 0, ERR_NONE, 1, 1, 1, 5'b00001, 0, 0, 0, 0, 5'b00001, 1));
    tbl.push_back(mk(1, 32'h0000DD00, ERR_DIVZERO, 0, 0, 1, 5'b00000, 1, 32'h0000DD00, ERR_DIVZERO, 1, 5'b01000, 1));
    tbl.push_back(mk(1, 32'h0000EE00, ERR_INEXACT, 0, 0, 0, 0, 1, 32'h0000DD00, ERR_DIVZERO, 2, 5'b01001, 1));
    tbl.push_back(mk(1, 32'hCAFEBABE, 3'd6, 0, 0, 0, 0, 1, 32'h0000DD00, ERR_DIVZERO, 3, 5'b01001, 1));
    tbl.push_back(mk(0, 0, ERR_NONE, 1, 0, 0, 0, 1, 32'h0000EE00, ERR_INEXACT, 2, 5'b01001, 1));
    tbl.push_back(mk(0, 0, ERR_NONE, 1, 0, 0, 0, 1, 32'hCAFEBABE, 3'd6, 1, 5'b01001, 1));
    tbl.push_back(mk(0, 0, ERR_NONE, 1, 1, 0, 0, 0, 0, 0, 0, 5'b00000, 1));
    foreach (tbl[i]) begin
      drive(tbl[i].iv, tbl[i].fp, tbl[i].err, tbl[i].ordy, tbl[i].clr, tbl[i].we, tbl[i].wd);
      tick;
      chk($sformatf("v%0d_out_valid", i), out_valid, tbl[i].ov);
      chk($sformatf("v%0d_count", i), count, tbl[i].ecnt);
      chk($sformatf("v%0d_fflags", i), fflags, tbl[i].eff);
      chk($sformatf("v%0d_in_ready", i), in_ready, tbl[i].eir);
      if (tbl[i].ov) begin
        chk($sformatf("v%0d_fp_q", i), fp_q, tbl[i].efp);
        chk($sformatf("v%0d_err_q", i), err_q, tbl[i].eerr);
      end
    end
    // streaming 1..10 with both sides always ready
    for (int k = 1; k <= 10; k++) begin
      drive(1, k, ERR_NONE, 1, 0, 0, 0);
      if (k > 1) chk($sformatf("stream_pop%0d", k - 1), fp_q, k - 1);
      tick;
      chk($sformatf("stream_count%0d", k), count, 1);
      chk($sformatf("stream_head%0d", k), fp_q, k);
    end
    drive(0, 0, ERR_NONE, 1, 0, 0, 0);
    chk("stream_pop10", fp_q, 10);
    tick;
    chk("stream_drain_count", count, 0);
    chk("stream_drain_valid", out_valid, 0);
    // reset mid-stream with in_valid high
    drive(1, 32'hA0000000, ERR_OVERFLOW, 0, 0, 0, 0); tick;
    drive(1, 32'hA0000001, ERR_NONE, 0, 0, 0, 0); tick;
    drive(1, 32'hA0000002, ERR_NONE, 0, 0, 0, 0); tick;
    chk("pre_rst_count", count, 3);
    chk("pre_rst_fflags", fflags, 5'b00100);
    drive(1, 32'hBEEF0000, ERR_INVALID, 1, 0, 0, 0);
    rst = 1;
    #1;
    chk("rst_hold_in_ready", in_ready, 0);
    tick;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_fflags", fflags, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    rst = 0;
    drive(0, 0, ERR_NONE, 0, 0, 0, 0);
    #1;
    chk("after_rst_in_ready", in_ready, 1);
    tick;
    chk("after_rst_count", count, 0);
    chk("after_rst_out_valid", out_valid, 0);
    chk("after_rst_fflags", fflags, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
